tt_vbhatt_uart_led_core: RTL and testbench
==========================================

TT_VBHATT_UART_LED_CORE -- requirements
Module: tt_vbhatt_uart_led

Interface
REQ-001 Parameter: CLKS_PER_BIT, default 1042, clock cycles per UART bit (10 MHz / 9600 baud); legal range 4..65535.
REQ-002 clk  input  1  sole clock; all state on rising edge.
REQ-003 rst_n  input  1  reset; one clock; reset is synchronous and active-high (asserted when 1, sampled on rising clk).
REQ-004 ena  input  1  design-select; ignored, no functional effect.
REQ-005 ui_in  input  8  bit 0 = UART RX (idle high); bits 7:1 unused.
REQ-006 uo_out  output  8  bits 6:0 = 7-segment drive (bit0=a..bit6=g, active-high); bit 7 = framing-error flag.
REQ-007 uio_in  input  8  unused.
REQ-008 uio_out  output  8  bit 0 = UART TX echo (idle high); bits 7:1 constant 0.
REQ-009 uio_oe  output  8  constant 8'b0000_0001.

Function
REQ-010 RX SHALL pass through a 2-flop synchronizer before use; all RX timing is counted from the synchronized signal.
REQ-011 RX FSM states SHALL be IDLE, START, DATA, STOP; 8N1 frame, LSB first.
REQ-012 IDLE -> START on synchronized RX = 0; counter reset to 0.
REQ-013 START: after CLKS_PER_BIT/2 cycles sample RX; 0 -> DATA, 1 -> IDLE (glitch rejected, no flags changed).
REQ-014 DATA: each bit sampled CLKS_PER_BIT cycles after previous sample (mid-bit); after 8th bit -> STOP.
REQ-015 STOP: sample after CLKS_PER_BIT cycles; 1 = valid byte, 0 = framing error; either way -> IDLE same cycle, ready for next start edge.
REQ-016 Valid byte: segment register and error flag SHALL update on the clock after the stop sample.
REQ-017 Decode: '0'..'9' (0x30-0x39) -> 0-9; 'A'..'F' (0x41-0x46) and 'a'..'f' (0x61-0x66) -> A-F; any other byte -> dash 0x40.
REQ-018 Segment codes 0..F: 3F 06 5B 4F 66 6D 7D 07 7F 6F 77 7C 39 5E 79 71.
REQ-019 Valid byte SHALL clear uo_out[7]; framing error SHALL set uo_out[7] and leave segments unchanged.
REQ-020 TX: on each valid byte, if TX idle, transmit the same byte 8N1 LSB first, each bit held exactly CLKS_PER_BIT cycles, starting the cycle after acceptance; total 10*CLKS_PER_BIT cycles.
REQ-021 Valid byte arriving while TX busy: display updates, echo dropped, in-flight TX frame unaffected.
REQ-022 Framing-error bytes SHALL NOT be echoed.
REQ-023 All outputs registered except constant uio_oe and uio_out[7:1].

Reset
REQ-024 While rst_n = 1: RX FSM IDLE, counters 0, synchronizer flops 1, uo_out = 8'h00 (blank, no error), uio_out[0] = 1, TX idle.
REQ-025 Reset asserted mid-frame SHALL abort RX and TX on that clock; no partial byte displayed or echoed; TX line returns high immediately.
REQ-026 After reset release, a start bit is recognized only on a high-to-low level seen by the synchronized RX.

Verification (CLKS_PER_BIT = 8 in bench)
REQ-027 Reset 2 cycles -> uo_out = 0x00, uio_out = 0x01, uio_oe = 0x01.
REQ-028 Send 0x35 ('5') -> uo_out = 0x6D within 3 cycles after stop mid-bit; uio_out[0] replays 0x35 frame, 80 cycles long.
REQ-029 Send 'a' (0x61) then 'F' (0x46) back-to-back -> uo_out 0x77 then 0x71; second echo dropped if first TX still busy.
REQ-030 Send 0x5A ('Z') -> uo_out = 0x40 (dash), echo 0x5A.
REQ-031 Send 0x33 with stop bit 0 -> uo_out[7] = 1, uo_out[6:0] unchanged, no TX activity; next valid '3' -> uo_out = 0x4F.
REQ-032 RX low pulse of 2 cycles -> no display change; assert rst_n mid-frame -> outputs return to reset values next clock.

Source files
------------

// File: rtl/tt_vbhatt_uart_led_core.sv
// UART-to-7-segment core: receives 8N1 bytes on ui_in[0], shows hex digits on
// uo_out[6:0], flags framing errors on uo_out[7] and echoes valid bytes on
// uio_out[0].
module tt_vbhatt_uart_led_core #(
    parameter int CLKS_PER_BIT = 1042
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    // Segment pattern for a hex digit, bit0 = a .. bit6 = g.
    function automatic logic [6:0] seg_of(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0:    s = 7'h3F;
            4'h1:    s = 7'h06;
            4'h2:    s = 7'h5B;
            4'h3:    s = 7'h4F;
            4'h4:    s = 7'h66;
            4'h5:    s = 7'h6D;
            4'h6:    s = 7'h7D;
            4'h7:    s = 7'h07;
            4'h8:    s = 7'h7F;
            4'h9:    s = 7'h6F;
            4'hA:    s = 7'h77;
            4'hB:    s = 7'h7C;
            4'hC:    s = 7'h39;
            4'hD:    s = 7'h5E;
            4'hE:    s = 7'h79;
            4'hF:    s = 7'h71;
            default: s = 7'h40;
        endcase
        return s;
    endfunction

    // ASCII hex character to segment pattern; anything else shows a dash.
    function automatic logic [6:0] decode(input logic [7:0] b);
        logic [6:0] s;
        if (b >= 8'h30 && b <= 8'h39) begin
            s = seg_of(b[3:0]);
        end else if ((b >= 8'h41 && b <= 8'h46) || (b >= 8'h61 && b <= 8'h66)) begin
            s = seg_of(b[3:0] + 4'd9);
        end else begin
            s = 7'h40;
        end
        return s;
    endfunction

    logic        sync1_r, sync2_r;
    logic        rx_s;
    rx_state_t   state_r, state_n;
    logic [15:0] cnt_r, cnt_n;
    logic [2:0]  idx_r, idx_n;
    logic [7:0]  shift_r, shift_n;
    logic        done_ok_s, done_err_s;
    logic        valid_r, ferr_pulse_r;
    logic [6:0]  seg_r;
    logic        ferr_r;
    logic        tx_busy_r, tx_line_r;
    logic [15:0] tx_cnt_r;
    logic [3:0]  tx_bit_r;
    logic [8:0]  tx_shift_r;
    logic        unused_s;

    assign rx_s     = sync2_r;
    assign unused_s = &{1'b0, ena, ui_in[7:1], uio_in};

    // Two-flop synchronizer for the asynchronous RX line (idles high).
    always_ff @(posedge clk) begin
        if (rst_n) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
        end else begin
            sync1_r <= ui_in[0];
            sync2_r <= sync1_r;
        end
    end

    // RX frame sequencing: next state, bit counter and shift register.
    always_comb begin
        state_n    = state_r;
        cnt_n      = cnt_r;
        idx_n      = idx_r;
        shift_n    = shift_r;
        done_ok_s  = 1'b0;
        done_err_s = 1'b0;
        case (state_r)
            IDLE: begin
                cnt_n = 16'd0;
                if (!rx_s) begin
                    state_n = START;
                end else begin
                    state_n = IDLE;
                end
            end
            START: begin
                if (cnt_r == HALF_LAST) begin
                    cnt_n = 16'd0;
                    idx_n = 3'd0;
                    if (!rx_s) begin
                        state_n = DATA;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    cnt_n = cnt_r + 16'd1;
                end
            end
            DATA: begin
                if (cnt_r == BIT_LAST) begin
                    cnt_n   = 16'd0;
                    shift_n = {rx_s, shift_r[7:1]};
                    if (idx_r == 3'd7) begin
                        state_n = STOP;
                    end else begin
                        idx_n = idx_r + 3'd1;
                    end
                end else begin
                    cnt_n = cnt_r + 16'd1;
                end
            end
            STOP: begin
                if (cnt_r == BIT_LAST) begin
                    cnt_n   = 16'd0;
                    state_n = IDLE;
                    if (rx_s) begin
                        done_ok_s = 1'b1;
                    end else begin
                        done_err_s = 1'b1;
                    end
                end else begin
                    cnt_n = cnt_r + 16'd1;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = 16'd0;
            end
        endcase
    end

    // RX state registers plus one-cycle completion pulses.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_r      <= IDLE;
            cnt_r        <= 16'd0;
            idx_r        <= 3'd0;
            shift_r      <= 8'h00;
            valid_r      <= 1'b0;
            ferr_pulse_r <= 1'b0;
        end else begin
            state_r      <= state_n;
            cnt_r        <= cnt_n;
            idx_r        <= idx_n;
            shift_r      <= shift_n;
            valid_r      <= done_ok_s;
            ferr_pulse_r <= done_err_s;
        end
    end

    // Display: valid bytes load the segments and clear the error flag;
    // framing errors only raise the flag.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            seg_r  <= 7'h00;
            ferr_r <= 1'b0;
        end else if (valid_r) begin
            seg_r  <= decode(shift_r);
            ferr_r <= 1'b0;
        end else if (ferr_pulse_r) begin
            ferr_r <= 1'b1;
        end else begin
            seg_r  <= seg_r;
            ferr_r <= ferr_r;
        end
    end

    // TX echo: a valid byte accepted while idle starts a 10-bit frame; bytes
    // arriving while busy are dropped so the frame in flight is untouched.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            tx_busy_r  <= 1'b0;
            tx_line_r  <= 1'b1;
            tx_cnt_r   <= 16'd0;
            tx_bit_r   <= 4'd0;
            tx_shift_r <= 9'h1FF;
        end else if (!tx_busy_r) begin
            if (valid_r) begin
                tx_busy_r  <= 1'b1;
                tx_line_r  <= 1'b0;
                tx_cnt_r   <= 16'd0;
                tx_bit_r   <= 4'd0;
                tx_shift_r <= {1'b1, shift_r};
            end else begin
                tx_line_r <= 1'b1;
            end
        end else if (tx_cnt_r == BIT_LAST) begin
            tx_cnt_r <= 16'd0;
            if (tx_bit_r == 4'd9) begin
                tx_busy_r <= 1'b0;
                tx_line_r <= 1'b1;
            end else begin
                tx_bit_r   <= tx_bit_r + 4'd1;
                tx_line_r  <= tx_shift_r[0];
                tx_shift_r <= {1'b1, tx_shift_r[8:1]};
            end
        end else begin
            tx_cnt_r <= tx_cnt_r + 16'd1;
        end
    end

    assign uo_out  = {ferr_r, seg_r};
    assign uio_out = {7'b000_0000, tx_line_r};
    assign uio_oe  = 8'b0000_0001;

endmodule

// File: tb/tb_tt_vbhatt_uart_led_core.sv
// Directed bench for the UART/7-segment core with an 8-cycle bit time.
module tb_tt_vbhatt_uart_led_core;

    localparam int CPB = 8;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic [7:0] exp_uo;
        logic       echo;
    } vec_t;

    vec_t vecs[13];

    tt_vbhatt_uart_led_core #(.CLKS_PER_BIT(CPB)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ena    (ena),
        .ui_in  (ui_in),
        .uo_out (uo_out),
        .uio_in (uio_in),
        .uio_out(uio_out),
        .uio_oe (uio_oe)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one 8N1 frame; called at a falling edge.
    task automatic send_byte(input logic [7:0] d, input logic stop);
        logic [9:0] frame;
        frame = {stop, d, 1'b0};
        for (int b = 0; b < 10; b++) begin
            ui_in[0] = frame[b];
            repeat (CPB) @(negedge clk);
        end
        ui_in[0] = 1'b1;
    endtask

    // Wait for an echo start bit, then check the first and last cycle of each bit.
    task automatic check_echo(input logic [7:0] d);
        int waited;
        logic [9:0] frame;
        waited = 0;
        frame = {1'b1, d, 1'b0};
        while (uio_out[0] !== 1'b0 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (waited >= 200) begin
            errors++;
            $display("FAIL echo_start: no start bit for %02h within 200 cycles", d);
        end else begin
            for (int r = 0; r < 10 * CPB; r++) begin
                if ((r % CPB) == 0 || (r % CPB) == CPB - 1) begin
                    check("echo_bit", {7'b0, uio_out[0]}, {7'b0, frame[r / CPB]});
                end
                @(negedge clk);
            end
        end
    endtask

    // TX line must stay high for n cycles.
    task automatic check_no_tx(input int n);
        logic seen_low;
        seen_low = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (uio_out[0] !== 1'b1) seen_low = 1'b1;
            @(negedge clk);
        end
        check("no_tx", {7'b0, seen_low}, 8'h00);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{8'h35, 1'b1, 8'h6D, 1'b1};
        vecs[1]  = '{8'h5A, 1'b1, 8'h40, 1'b1};
        vecs[2]  = '{8'h33, 1'b0, 8'hC0, 1'b0};
        vecs[3]  = '{8'h33, 1'b1, 8'h4F, 1'b1};
        vecs[4]  = '{8'h39, 1'b1, 8'h6F, 1'b1};
        vecs[5]  = '{8'h62, 1'b1, 8'h7C, 1'b1};
        vecs[6]  = '{8'h43, 1'b1, 8'h39, 1'b1};
        vecs[7]  = '{8'h2F, 1'b1, 8'h40, 1'b1};
        vecs[8]  = '{8'h47, 1'b1, 8'h40, 1'b1};
        vecs[9]  = '{8'h30, 1'b1, 8'h3F, 1'b1};
        vecs[10] = '{8'h67, 1'b1, 8'h40, 1'b1};
        vecs[11] = '{8'h64, 1'b1, 8'h5E, 1'b1};
        vecs[12] = '{8'h45, 1'b1, 8'h79, 1'b1};

        ena    = 1'b1;
        uio_in = 8'h00;
        ui_in  = 8'h01;
        rst_n  = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_uo", uo_out, 8'h00);
        check("reset_uio_out", uio_out, 8'h01);
        check("reset_uio_oe", uio_oe, 8'h01);
        rst_n = 1'b0;
        repeat (5) @(negedge clk);

        // Table of single frames.
        for (int i = 0; i < 13; i++) begin
            fork
                send_byte(vecs[i].data, vecs[i].stop);
                begin
                    if (vecs[i].echo) check_echo(vecs[i].data);
                    else check_no_tx(100);
                end
            join
            check("vec_uo", uo_out, vecs[i].exp_uo);
        end

        // Two-cycle low glitch on RX is rejected.
        ui_in[0] = 1'b0;
        repeat (2) @(negedge clk);
        ui_in[0] = 1'b1;
        check_no_tx(40);
        check("glitch_uo", uo_out, 8'h79);

        // Back-to-back 'a' then 'F': second echo dropped, TX still busy.
        fork
            begin
                send_byte(8'h61, 1'b1);
                check("b2b_first_uo", uo_out, 8'h77);
                send_byte(8'h46, 1'b1);
            end
            begin
                check_echo(8'h61);
                check_no_tx(100);
            end
        join
        check("b2b_second_uo", uo_out, 8'h71);

        // Reset while the echo is mid-frame.
        send_byte(8'h30, 1'b1);
        check("pre_tx_reset_uo", uo_out, 8'h3F);
        repeat (20) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("tx_reset_uo", uo_out, 8'h00);
        check("tx_reset_uio_out", uio_out, 8'h01);
        rst_n = 1'b0;
        check_no_tx(100);
        check("tx_reset_after_uo", uo_out, 8'h00);

        // Reset while a frame is being received: nothing shown or echoed.
        fork
            send_byte(8'hFF, 1'b1);
            begin
                repeat (30) @(negedge clk);
                rst_n = 1'b1;
                @(negedge clk);
                check("rx_reset_uo", uo_out, 8'h00);
                check("rx_reset_uio_out", uio_out, 8'h01);
                rst_n = 1'b0;
            end
        join
        check_no_tx(100);
        check("rx_reset_after_uo", uo_out, 8'h00);

        // Recovery after reset.
        fork
            send_byte(8'h37, 1'b1);
            check_echo(8'h37);
        join
        check("recover_uo", uo_out, 8'h07);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
